// File: rtl/display_sequencer_if.sv
// rtl/display_sequencer_if.sv - status inputs, tick strobe and display index outputs of the sequencer
//
// master: the side that drives tick and the raw status inputs and receives the indices.
// slave : the sequencer, which receives tick/status and drives msg_sel, char_idx, col_idx,
//         blank, restart and msg_done.
interface display_sequencer_if;
    logic       tick;
    logic       aceito;
    logic       comprometido;
    logic       rejeitado;
    logic [1:0] msg_sel;
    logic [3:0] char_idx;
    logic [2:0] col_idx;
    logic       blank;
    logic       restart;
    logic       msg_done;

    modport master (
        output tick, aceito, comprometido, rejeitado,
        input  msg_sel, char_idx, col_idx, blank, restart, msg_done
    );

    modport slave (
        input  tick, aceito, comprometido, rejeitado,
        output msg_sel, char_idx, col_idx, blank, restart, msg_done
    );
endinterface

// File: rtl/display_sequencer.sv
// rtl/display_sequencer.sv - arbitrates status inputs and sequences 5x7 display char/column indices
//
// Ports:
//   clk50Mhz : system clock, all state on the rising edge
//   rst      : asynchronous active-low reset
//   bus      : display_sequencer_if.slave
//              tick                          column-rate strobe, one cycle wide
//              aceito/comprometido/rejeitado raw asynchronous status inputs
//              msg_sel                       0 none, 1 aceito, 2 comprometido, 3 rejeitado
//              char_idx / col_idx            current character / column slot
//              blank                         matrix shows no pixels
//              restart                       one-cycle pulse on a newly accepted selection
//              msg_done                      one-cycle pulse when the last column completes
module display_sequencer #(
    parameter int LEN_ACEITO      = 6,
    parameter int LEN_COMPROMETIDO = 12,
    parameter int LEN_REJEITADO   = 9,
    parameter int COLS            = 6,
    parameter int GAP_COLS        = 8,
    parameter int STABLE_TICKS    = 3
) (
    input  logic                clk50Mhz,
    input  logic                rst,
    display_sequencer_if.slave  bus
);
    localparam int FW = $clog2(STABLE_TICKS + 1);
    localparam int GW = $clog2(GAP_COLS + 1);

    localparam logic [FW-1:0] STABLE_MAX = FW'(STABLE_TICKS);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_COLS - 1);
    localparam logic [2:0]    COL_LAST   = 3'(COLS - 1);
    localparam logic [3:0]    LAST_A     = 4'(LEN_ACEITO - 1);
    localparam logic [3:0]    LAST_C     = 4'(LEN_COMPROMETIDO - 1);
    localparam logic [3:0]    LAST_R     = 4'(LEN_REJEITADO - 1);

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    // Synchronizers, bit order {rejeitado, comprometido, aceito}
    logic [2:0] sync1;
    logic [2:0] sync2;

    always_ff @(posedge clk50Mhz or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {bus.rejeitado, bus.comprometido, bus.aceito};
            sync2 <= sync1;
        end
    end

    logic [1:0] candidate;

    always_comb begin
        candidate = 2'd0;
        if (sync2[2])      candidate = 2'd3;
        else if (sync2[1]) candidate = 2'd2;
        else if (sync2[0]) candidate = 2'd1;
    end

    // Stability filter: any change of candidate restarts the count immediately,
    // so glitches shorter than STABLE_TICKS ticks never reach acceptance.
    logic [1:0]    pending;
    logic [FW-1:0] stable_cnt;

    always_ff @(posedge clk50Mhz or negedge rst) begin
        if (!rst) begin
            pending    <= 2'd0;
            stable_cnt <= '0;
        end else if (candidate != pending) begin
            pending    <= candidate;
            stable_cnt <= '0;
        end else if (bus.tick && stable_cnt != STABLE_MAX) begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    state_t        state_q, state_n;
    logic [1:0]    msg_sel_q, msg_sel_n;
    logic [3:0]    char_q, char_n;
    logic [2:0]    col_q, col_n;
    logic [GW-1:0] gap_q, gap_n;
    logic          blank_q, blank_n;
    logic          restart_q, restart_n;
    logic          done_q, done_n;
    logic [3:0]    last_char;
    logic          accept;

    assign accept = (stable_cnt == STABLE_MAX) && (candidate == pending) && (pending != msg_sel_q);

    always_comb begin
        last_char = 4'd0;
        case (msg_sel_q)
            2'd1:    last_char = LAST_A;
            2'd2:    last_char = LAST_C;
            2'd3:    last_char = LAST_R;
            default: last_char = 4'd0;
        endcase
    end

    always_ff @(posedge clk50Mhz or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            msg_sel_q <= 2'd0;
            char_q    <= 4'd0;
            col_q     <= 3'd0;
            gap_q     <= '0;
            blank_q   <= 1'b1;
            restart_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            msg_sel_q <= msg_sel_n;
            char_q    <= char_n;
            col_q     <= col_n;
            gap_q     <= gap_n;
            blank_q   <= blank_n;
            restart_q <= restart_n;
            done_q    <= done_n;
        end
    end

    // Acceptance takes precedence over a tick in the same cycle, which also
    // suppresses msg_done if the tick would have completed the message.
    always_comb begin
        state_n   = state_q;
        msg_sel_n = msg_sel_q;
        char_n    = char_q;
        col_n     = col_q;
        gap_n     = gap_q;
        restart_n = 1'b0;
        done_n    = 1'b0;

        if (accept) begin
            msg_sel_n = pending;
            restart_n = 1'b1;
            char_n    = 4'd0;
            col_n     = 3'd0;
            gap_n     = '0;
            state_n   = (pending == 2'd0) ? IDLE : SHOW;
        end else begin
            case (state_q)
                IDLE: begin
                    char_n = 4'd0;
                    col_n  = 3'd0;
                    gap_n  = '0;
                end
                SHOW: begin
                    if (bus.tick) begin
                        if (col_q == COL_LAST) begin
                            col_n = 3'd0;
                            if (char_q == last_char) begin
                                done_n  = 1'b1;
                                char_n  = 4'd0;
                                gap_n   = '0;
                                state_n = GAP;
                            end else begin
                                char_n = char_q + 4'd1;
                            end
                        end else begin
                            col_n = col_q + 3'd1;
                        end
                    end
                end
                GAP: begin
                    if (bus.tick) begin
                        if (gap_q == GAP_LAST) begin
                            gap_n   = '0;
                            state_n = SHOW;
                        end else begin
                            gap_n = gap_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        blank_n = (state_n != SHOW);
    end

    assign bus.msg_sel  = msg_sel_q;
    assign bus.char_idx = char_q;
    assign bus.col_idx  = col_q;
    assign bus.blank    = blank_q;
    assign bus.restart  = restart_q;
    assign bus.msg_done = done_q;
endmodule

// File: tb/tb_display_sequencer.sv
// tb/tb_display_sequencer.sv - scoreboard bench for display_sequencer with a linear-position reference model
module tb_display_sequencer;
    localparam int LA   = 6;
    localparam int LC   = 12;
    localparam int LR   = 9;
    localparam int COLS = 6;
    localparam int GAPC = 8;
    localparam int STAB = 3;
    localparam logic [11:0] RESET_VEC = 12'h004;

    logic clk50Mhz = 1'b0;
    logic rst      = 1'b0;

    display_sequencer_if bus();

    display_sequencer #(
        .LEN_ACEITO(LA), .LEN_COMPROMETIDO(LC), .LEN_REJEITADO(LR),
        .COLS(COLS), .GAP_COLS(GAPC), .STABLE_TICKS(STAB)
    ) dut (
        .clk50Mhz(clk50Mhz),
        .rst(rst),
        .bus(bus)
    );

    always #10 clk50Mhz = ~clk50Mhz;

    int total = 0;
    int bad   = 0;

    logic [11:0] exp_q[$];
    string       tag_q[$];

    // model: selected code, linear position in the repeat period, filter state
    int m_sel  = 0;
    int m_pos  = 0;
    int m_pend = 0;
    int m_cnt  = 0;

    logic tick_d;
    always @(posedge clk50Mhz or negedge rst) begin
        if (!rst) tick_d <= 1'b0;
        else      tick_d <= bus.tick;
    end

    function automatic logic [11:0] dut_vec();
        return {bus.msg_sel, bus.char_idx, bus.col_idx, bus.blank, bus.restart, bus.msg_done};
    endfunction

    function automatic int len_of(int s);
        case (s)
            1:       return LA;
            2:       return LC;
            3:       return LR;
            default: return 0;
        endcase
    endfunction

    function automatic logic [11:0] model_rec(logic rs, logic dn);
        int   show_len;
        int   ch;
        int   co;
        logic bl;
        show_len = len_of(m_sel) * COLS;
        if (m_sel == 0 || m_pos >= show_len) begin
            ch = 0; co = 0; bl = 1'b1;
        end else begin
            ch = m_pos / COLS; co = m_pos % COLS; bl = 1'b0;
        end
        return {2'(m_sel), 4'(ch), 3'(co), bl, rs, dn};
    endfunction

    logic [11:0] mon_exp;
    string       mon_tag;

    always @(negedge clk50Mhz) begin
        if (rst && (tick_d || bus.restart || bus.msg_done)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got %h required no event", dut_vec());
            end else begin
                mon_exp = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
                if (dut_vec() !== mon_exp) begin
                    bad++;
                    $display("FAIL %s: got %h required %h", mon_tag, dut_vec(), mon_exp);
                end
            end
        end
    end

    task automatic check_now(input string name, input logic [11:0] want);
        total++;
        if (dut_vec() !== want) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, dut_vec(), want);
        end
    endtask

    task automatic set_in(input logic a, input logic c, input logic r);
        int code;
        @(negedge clk50Mhz);
        bus.aceito       = a;
        bus.comprometido = c;
        bus.rejeitado    = r;
        code = r ? 3 : (c ? 2 : (a ? 1 : 0));
        if (code != m_pend) begin
            m_pend = code;
            m_cnt  = 0;
        end
        repeat (4) @(negedge clk50Mhz);
    endtask

    task automatic do_tick(input string tg);
        logic dn;
        @(negedge clk50Mhz);
        bus.tick = 1'b1;
        dn = 1'b0;
        if (m_sel != 0) begin
            m_pos = (m_pos + 1) % (len_of(m_sel) * COLS + GAPC);
            dn = (m_pos == len_of(m_sel) * COLS);
        end
        exp_q.push_back(model_rec(1'b0, dn));
        tag_q.push_back(tg);
        if (m_cnt < STAB) m_cnt++;
        if (m_cnt == STAB && m_pend != m_sel) begin
            m_sel = m_pend;
            m_pos = 0;
            exp_q.push_back(model_rec(1'b1, 1'b0));
            tag_q.push_back({tg, "_restart"});
        end
        @(negedge clk50Mhz);
        bus.tick = 1'b0;
        repeat ($urandom_range(2, 4)) @(negedge clk50Mhz);
    endtask

    task automatic ticks(input int n, input string tg);
        for (int i = 0; i < n; i++) do_tick(tg);
    endtask

    initial begin
        bus.tick = 1'b0;
        bus.aceito = 1'b0;
        bus.comprometido = 1'b0;
        bus.rejeitado = 1'b0;
        repeat (3) @(negedge clk50Mhz);
        check_now("reset_state", RESET_VEC);
        rst = 1'b1;

        set_in(1'b1, 1'b0, 1'b0);
        ticks(3, "accept_aceito");
        ticks(36, "show_aceito");
        ticks(8, "gap_aceito");
        ticks(20, "to_char3_col2");
        check_now("pos_char3_col2", model_rec(1'b0, 1'b0));

        set_in(1'b0, 1'b1, 1'b0);
        ticks(2, "glitch_comp");
        set_in(1'b1, 1'b0, 1'b0);
        ticks(3, "after_glitch");
        check_now("glitch_no_change", model_rec(1'b0, 1'b0));

        set_in(1'b1, 1'b0, 1'b1);
        ticks(3, "accept_rejeitado");
        ticks(60, "show_rejeitado");

        set_in(1'b0, 1'b0, 1'b0);
        ticks(3, "deassert_all");
        check_now("idle_after_deassert", RESET_VEC);

        set_in(1'b0, 1'b1, 1'b0);
        ticks(3, "accept_comp");
        ticks(10, "show_comp");

        @(negedge clk50Mhz);
        bus.tick = 1'b1;
        #2 rst = 1'b0;
        #1 check_now("async_reset_mid_show", RESET_VEC);
        @(negedge clk50Mhz);
        bus.tick = 1'b0;
        repeat (2) @(negedge clk50Mhz);
        check_now("reset_held", RESET_VEC);
        rst = 1'b1;
        m_sel = 0; m_pos = 0; m_pend = 0; m_cnt = 0;
        set_in(1'b0, 1'b1, 1'b0);
        ticks(3, "post_reset_reaccept");

        for (int it = 0; it < 30; it++) begin
            logic [2:0] bits;
            bits = 3'($urandom_range(0, 7));
            set_in(bits[0], bits[1], bits[2]);
            ticks($urandom_range(1, 14), "random");
        end

        repeat (8) @(negedge clk50Mhz);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drained: got %0d pending required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
